// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative CORDIC rotation computing cos/sin of a clamped angle
module cordic_rotator #(
  parameter int WIDTH = 20,
  parameter int FRAC = 15,
  parameter int ITER = 16,
  parameter logic [WIDTH-1:0] X0 = 20'h4DBA,
  parameter logic [WIDTH-1:0] HALFPI = 20'hC90F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] angle,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cos,
  output logic [WIDTH-1:0] sin,
  output logic             clip
);
  localparam int DW = WIDTH + 2;
  localparam logic [31:0] ATAN [16] = '{
    32'h6487ED51, 32'h3B58CE0A, 32'h1F5B75F9, 32'h0FEADD4C,
    32'h07FD56ED, 32'h03FFAAB7, 32'h01FFF555, 32'h00FFFEAA,
    32'h007FFFD5, 32'h003FFFFA, 32'h001FFFFF, 32'h000FFFFF,
    32'h0007FFFF, 32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic signed [DW-1:0] x, y, z, xn, yn, zn, at;
  logic signed [WIDTH-1:0] hp, a, ac;
  logic [3:0] i;
  logic accept, last, over, under;

  function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    return (v[DW-1:WIDTH-1] == {(DW-WIDTH+1){v[DW-1]}}) ? v[WIDTH-1:0] :
           {v[DW-1], {(WIDTH-1){~v[DW-1]}}};
  endfunction

  assign hp = HALFPI;
  assign a = angle;
  assign over = a > hp;
  assign under = a < -hp;
  assign ac = over ? hp : under ? -hp : a;
  assign accept = start && state != RUN;
  assign last = i == 4'(ITER - 1);
  assign busy = state == RUN;
  assign done = state == DONE;

  // next state: accept from IDLE/DONE, run ITER cycles, one DONE cycle
  always_comb begin
    state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end

  // one micro-rotation on the pre-cycle x, y, z
  always_comb begin
    at = DW'(ATAN[i] >> (31 - FRAC));
    xn = z[DW-1] ? x + (y >>> i) : x - (y >>> i);
    yn = z[DW-1] ? y - (x >>> i) : y + (x >>> i);
    zn = z[DW-1] ? z + at : z - at;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // datapath: load on accept, iterate while running, publish on last iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      cos <= '0;
      sin <= '0;
      clip <= 1'b0;
    end else if (accept) begin
      x <= {{2{X0[WIDTH-1]}}, X0};
      y <= '0;
      z <= {{2{ac[WIDTH-1]}}, ac};
      i <= '0;
      clip <= over | under;
    end else if (busy) begin
      x <= xn;
      y <= yn;
      z <= zn;
      i <= i + 4'd1;
      if (last) begin
        cos <= sat(xn);
        sin <= sat(yn);
      end
    end
  end
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed and swept checks of the CORDIC rotator
module tb_cordic_rotator;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy, done, clip;
  logic [19:0] angle = '0, cos, sin;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cordic_rotator dut (
    .clk(clk), .reset(reset), .start(start), .angle(angle),
    .busy(busy), .done(done), .cos(cos), .sin(sin), .clip(clip)
  );

  typedef struct {
    logic [19:0] a;
    int c;
    int s;
    int k;
  } vec_t;
  vec_t vecs [12];

  function automatic int sv(input logic [19:0] v);
    return int'($signed(v));
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic run_op(input logic [19:0] a, output int lat);
    int nb = 0;
    @(negedge clk);
    start = 1'b1;
    angle = a;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      nb += int'(busy);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 17, 0);
    check("busy_cycles", nb, 16, 0);
    check("busy_in_done", int'(busy), 0, 0);
  endtask

  initial begin
    int lat, nd, ai;
    real r;
    vecs[0]  = '{20'h00000, 32768, 0, 0};
    vecs[1]  = '{20'h06487, 23170, 23170, 0};
    vecs[2]  = '{20'hF9B79, 23170, -23170, 0};
    vecs[3]  = '{20'h10000, 0, 32768, 1};
    vecs[4]  = '{20'h00000, 32768, 0, 0};
    vecs[5]  = '{20'hF0000, 0, -32768, 1};
    vecs[6]  = '{20'h0C90F, 0, 32768, 0};
    vecs[7]  = '{20'hF36F1, 0, -32768, 0};
    vecs[8]  = '{20'h0C910, 0, 32768, 1};
    vecs[9]  = '{20'h04305, 28378, 16384, 0};
    vecs[10] = '{20'h80000, 0, -32768, 1};
    vecs[11] = '{20'h7FFFF, 0, 32768, 1};

    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_cos", sv(cos), 0, 0);
    check("rst_sin", sv(sin), 0, 0);
    check("rst_clip", int'(clip), 0, 0);
    reset = 1'b0;

    foreach (vecs[n]) begin
      run_op(vecs[n].a, lat);
      check($sformatf("vec%0d_cos", n), sv(cos), vecs[n].c, 16);
      check($sformatf("vec%0d_sin", n), sv(sin), vecs[n].s, 16);
      check($sformatf("vec%0d_clip", n), int'(clip), vecs[n].k, 0);
    end

    @(negedge clk);
    start = 1'b1;
    angle = 20'h06487;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      check("b2b_done", int'(done), int'(c % 17 == 0), 0);
      check("b2b_busy", int'(busy), int'(c % 17 != 0), 0);
      if (c % 17 == 0) begin
        check("b2b_cos", sv(cos), 23170, 16);
        check("b2b_sin", sv(sin), 23170, 16);
        check("b2b_clip", int'(clip), 0, 0);
      end
      angle = (c % 17 >= 5 && c % 17 <= 10) ? 20'h10000 : 20'h06487;
      if (c == 51) start = 1'b0;
    end

    @(negedge clk);
    start = 1'b1;
    angle = 20'h10000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_cos", sv(cos), 0, 0);
    check("abort_sin", sv(sin), 0, 0);
    check("abort_clip", int'(clip), 0, 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("abort_no_done", nd, 0, 0);
    run_op(20'h04305, lat);
    check("after_abort_cos", sv(cos), 28378, 16);
    check("after_abort_sin", sv(sin), 16384, 16);

    for (int n = 0; n < 1000; n++) begin
      ai = int'($urandom_range(0, 2 * 51471)) - 51471;
      run_op(20'(ai), lat);
      r = real'(ai) / 32768.0;
      check("sweep_cos", sv(cos), int'($cos(r) * 32768.0), 16);
      check("sweep_sin", sv(sin), int'($sin(r) * 32768.0), 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
